// File: rtl/op5_operand_queue.sv
// op5_operand_queue
// Assembles serial operand words (a, b, c, d, repeat) into {a,b,c,d} quads,
// buffers up to DEPTH complete quads and presents the head quad to the
// four-operand product stage with the STB/BUSY handshake.
//
// Parameters:
//   DEPTH    number of complete quads buffered (power of two, >= 2)
//   WIDTH    operand word width
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous, active-low reset
//   in_data        operand word, order a, b, c, d
//   in_STB         in_data valid
//   in_BUSY        queue cannot take in_data this cycle
//   out_a..out_d   head-quad operands (stale storage when out_STB==0)
//   out_STB        head quad valid
//   op5_BUSY       busy from the product stage
//   count          number of complete quads stored
//   word_idx       next operand slot expected (0=a .. 3=d)
//   flush          (only when OP5Q_FLUSH_EN is defined) clears count,
//                  word_idx and both pointers; storage is left untouched
//
// Optional feature macro: OP5Q_FLUSH_EN
module op5_operand_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_STB,
  output logic                         in_BUSY,
  output logic [WIDTH-1:0]             out_a,
  output logic [WIDTH-1:0]             out_b,
  output logic [WIDTH-1:0]             out_c,
  output logic [WIDTH-1:0]             out_d,
  output logic                         out_STB,
  input  logic                         op5_BUSY,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [1:0]                   word_idx
`ifdef OP5Q_FLUSH_EN
  ,
  input  logic                         flush
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0]   hold_a;
  logic [WIDTH-1:0]   hold_b;
  logic [WIDTH-1:0]   hold_c;
  logic [4*WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;

  logic take;
  logic push;
  logic pop;
  logic do_flush;

`ifdef OP5Q_FLUSH_EN
  assign do_flush = flush;
`else
  assign do_flush = 1'b0;
`endif

  // Only the completing d word can stall: a, b, c always fit in holding slots.
  assign in_BUSY = (word_idx == 2'd3) && (count == FULL);
  assign take    = in_STB && !in_BUSY;
  assign push    = take && (word_idx == 2'd3);
  assign out_STB = (count != {CW{1'b0}});
  assign pop     = out_STB && !op5_BUSY;

  assign {out_a, out_b, out_c, out_d} = mem[rd_ptr];

  // Holding slots, word index, FIFO storage, pointers and quad count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_a   <= {WIDTH{1'b0}};
      hold_b   <= {WIDTH{1'b0}};
      hold_c   <= {WIDTH{1'b0}};
      word_idx <= 2'd0;
      wr_ptr   <= {PW{1'b0}};
      rd_ptr   <= {PW{1'b0}};
      count    <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {(4*WIDTH){1'b0}};
      end
    end else if (do_flush) begin
      // Flush wins over any concurrent transfer; storage keeps its contents.
      word_idx <= 2'd0;
      wr_ptr   <= {PW{1'b0}};
      rd_ptr   <= {PW{1'b0}};
      count    <= {CW{1'b0}};
    end else begin
      if (take) begin
        case (word_idx)
          2'd0:    hold_a <= in_data;
          2'd1:    hold_b <= in_data;
          2'd2:    hold_c <= in_data;
          default: hold_c <= hold_c;
        endcase
        word_idx <= word_idx + 2'd1;
      end
      if (push) begin
        mem[wr_ptr] <= {hold_a, hold_b, hold_c, in_data};
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/op5_operand_queue.md
Name: op5_operand_queue

Overview:
- Upstream feeder for the four-operand product stage, which computes (a*b)*(c*d) and accepts a new job on op5_input_STB && !op5_BUSY.
- Collects 32-bit operand words one at a time from the command/datapath side and assembles them into {a,b,c,d} quads.
- Buffers up to DEPTH complete quads in a FIFO and presents the head quad to the product stage with the team's STB/BUSY handshake.
- Decouples the serial word source from the long multi-cycle latency of the product stage.

Parameters:
- DEPTH, 4, number of complete quads buffered; power of two, >= 2.
- WIDTH, 32, operand word width (IEEE-754 single).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset; synchronous, active-low.
- in_data  input  WIDTH  operand word; order is a, b, c, d, then repeat.
- in_STB  input  1  in_data valid.
- in_BUSY  output  1  queue cannot take in_data this cycle.
- out_a / out_b / out_c / out_d  output  WIDTH each  head-quad operands, wired to input_a..input_d of the product stage.
- out_STB  output  1  head quad valid; wired to op5_input_STB.
- op5_BUSY  input  1  busy from the product stage.
- count  output  $clog2(DEPTH+1)  number of complete quads stored.
- word_idx  output  2  next operand slot expected: 0=a, 1=b, 2=c, 3=d.

Behaviour:
- Input transfer: occurs at an edge where in_STB && !in_BUSY. Output transfer: occurs at an edge where out_STB && !op5_BUSY.
- in_BUSY is combinational: (word_idx==3) && (count==DEPTH).
  - Words a, b and c always land in holding registers.
  - Only the completing d word can stall.
- Assembly:
  - Each input transfer stores in_data in holding slot word_idx, then increments word_idx, wrapping 3 to 0.
  - A transfer with word_idx==3 writes {hold_a, hold_b, hold_c, in_data} into the FIFO at wr_ptr, advances wr_ptr and increments count.
- Output side:
  - out_STB = (count != 0).
  - out_a..out_d are combinational reads of the entry at rd_ptr.
  - An output transfer advances rd_ptr and decrements count.
  - The product stage raises op5_BUSY the cycle after acceptance, so a held out_STB does not double-issue.
- Pointers are log2(DEPTH) bits and wrap naturally. count is the single source of full/empty.
- Simultaneous push and pop:
  - When count<DEPTH, both take effect and count is unchanged.
  - When count==DEPTH, the push is blocked by in_BUSY. The pop proceeds and the d word is accepted on a later cycle. There is no same-cycle bypass.
- Empty queue: out_STB=0 and out_* show stale storage. The consumer must ignore out_* without out_STB.
- in_STB while in_BUSY: the word is not taken and no state changes. The source must hold in_data and in_STB.
- Reset values (rst==0 at an edge):
  - count=0, word_idx=0, wr_ptr=rd_ptr=0.
  - out_STB=0, in_BUSY=0.
  - Holding registers and FIFO storage cleared to 0, so out_a..out_d = 0.
  - Reset mid-assembly or with quads queued discards everything. There is no partial-quad recovery.
- Latency:
  - Word d accepted at edge N, into an empty queue: out_STB=1 after edge N.
  - Earliest consumer acceptance is at edge N+1.

Optional Feature:
- Macro: OP5Q_FLUSH_EN.
- Defined:
  - Adds input port flush (1 bit).
  - flush==1 at an edge clears count, word_idx and both pointers; storage contents are untouched.
  - flush overrides any simultaneous input or output transfer; neither takes effect.
  - rst has priority over flush.
- Not defined:
  - No flush port.
  - The only way to discard queued or partial data is rst.

Test Plan:
- Single quad:
  - Stimulus: after reset, op5_BUSY=0, send 0x3F800000, 0x40000000, 0x40400000, 0x40800000 on consecutive cycles.
  - Response: word_idx steps 1,2,3,0; out_STB rises one cycle after the 4th word; out_a..out_d equal those values; count 1→0 after acceptance.
- Fill to full:
  - Stimulus: op5_BUSY=1, send 4 quads (DEPTH=4), then words a, b, c of a 5th quad.
  - Response: count=4; in_BUSY=0 while word_idx<3, in_BUSY=1 at word_idx==3; 5th d word held until op5_BUSY drops for one cycle, then count returns to 4.
- Ordering/wrap:
  - Stimulus: push 6 quads with first words 0x1..0x6, consumer draining intermittently.
  - Response: out_a sequence on accepted transfers is exactly 0x1..0x6 across pointer wrap.
- Simultaneous push/pop:
  - Stimulus: count=2, d word accepted in the same cycle as a consumer acceptance.
  - Response: count stays 2; head advances to the next quad.
- Reset mid-operation:
  - Stimulus: count=3, word_idx=2, rst=0 for one edge.
  - Response: count=0, word_idx=0, out_STB=0, out_a..out_d=0; next word goes to slot a.
- Flush (OP5Q_FLUSH_EN):
  - Stimulus: count=2, word_idx=1, flush=1 together with in_STB=1.
  - Response: count=0, word_idx=0, out_STB=0; the concurrent word is dropped.
